// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier driving an external combinational adder.
// Produces a 2*WIDTH-bit product WIDTH cycles after an accepted start, with a one-cycle done pulse.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_x,
  output logic [WIDTH-1:0]   add_y,
  output logic               add_mode,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load_c;
  logic             shift_c;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    count_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift_c = 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture and partial-product shift; the adder's carry becomes the new top bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (load_c) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_hi_q <= '0;
      count_q  <= '0;
    end else if (shift_c) begin
      {acc_hi_q, mplier_q} <= {add_cout, add_sum, mplier_q[WIDTH-1:1]};
      count_q              <= count_q + CW'(1);
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign product  = {acc_hi_q, mplier_q};
  assign add_x    = acc_hi_q;
  assign add_y    = mplier_q[0] ? mcand_q : '0;
  assign add_mode = 1'b0;
  assign add_cin  = 1'b0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier with a behavioural 8-bit adder attached.
// Directed vector table, multi-cycle corner sequences and a random operand sweep.
module tb_shift_add_multiplier;

  localparam int unsigned W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_x;
  logic [W-1:0]   add_y;
  logic           add_mode;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  int tests;
  int fails;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_mode (add_mode),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Downstream carry-lookahead adder modelled as a plain add
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi);
    start = 1'b1;
    a     = ai;
    b     = bi;
    tick();
    start = 1'b0;
  endtask

  // Counts edges from the accept edge (1) until done is visible; also counts busy cycles
  task automatic wait_done(output int cyc, output int busycnt, output bit ok);
    cyc     = 1;
    busycnt = 0;
    ok      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busycnt++;
      tick();
      cyc++;
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int cyc;
    int bc;
    bit ok;
    logic [2*W-1:0] hold;

    tests = 0;
    fails = 0;
    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
    vecs[5] = '{a: 8'd255, b: 8'd1,   p: 16'd255};
    vecs[6] = '{a: 8'd1,   b: 8'd255, p: 16'd255};
    vecs[7] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    vecs[8] = '{a: 8'd100, b: 8'd100, p: 16'd10000};
    vecs[9] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_done",    32'(done),     32'd0);
    check("rst_product", 32'(product),  32'd0);
    check("rst_add_x",   32'(add_x),    32'd0);
    check("rst_add_y",   32'(add_y),    32'd0);
    check("add_mode",    32'(add_mode), 32'd0);
    check("add_cin",     32'(add_cin),  32'd0);
    reset = 1'b0;
    tick();

    // Table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(cyc, bc, ok);
      check("vec_product", 32'(product), 32'(vecs[i].p));
      check("vec_latency", 32'(cyc),     32'd9);
      check("vec_busy",    32'(bc),      32'd8);
      hold = product;
      tick();
      check("vec_done_pulse", 32'(done), 32'd0);
      tick();
      check("vec_hold", 32'(product), 32'(hold));
    end

    // Start during RUN is ignored
    start_op(8'd7, 8'd6);
    tick();
    tick();
    start_op(8'd1, 8'd1);
    wait_done(cyc, bc, ok);
    check("ignore_product", 32'(product), 32'd42);
    check("ignore_latency", 32'(cyc + 3), 32'd9);
    tick();

    // Asynchronous reset mid-RUN
    start_op(8'd9, 8'd9);
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_done",    32'(done),    32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_add_x",   32'(add_x),   32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    start_op(8'd3, 8'd5);
    wait_done(cyc, bc, ok);
    check("post_rst_product", 32'(product), 32'd15);

    // Back-to-back: start held through DONE
    tick();
    start_op(8'd13, 8'd11);
    wait_done(cyc, bc, ok);
    start = 1'b1;
    a     = 8'd10;
    b     = 8'd20;
    check("b2b_first_done",    32'(done),    32'd1);
    check("b2b_first_product", 32'(product), 32'd143);
    tick();
    start = 1'b0;
    check("b2b_rerun_busy", 32'(busy), 32'd1);
    check("b2b_rerun_done", 32'(done), 32'd0);
    wait_done(cyc, bc, ok);
    check("b2b_second_product", 32'(product), 32'd200);
    check("b2b_latency",        32'(cyc),     32'd9);
    tick();

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      start_op(ra, rb);
      wait_done(cyc, bc, ok);
      check("rand_product", 32'(product), 32'(16'(ra) * 16'(rb)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
